pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
- Parametrised program-sequencing counter for the processor fetch stage; next generation of the 4-bit loadable/countable PC.
- Adds configurable width, relative branches, stall, and a DEPTH-entry hardware return-address stack (call/return).
- Sticky error reporting on stack misuse.
- Sits between the control unit (op/target) and instruction memory address (pc).

Parameters:
- WIDTH, 8, PC and target width in bits (>= 4).
- DEPTH, 4, return-stack entries (>= 1).
- RESET_ADDR, 0, value loaded into pc on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; clock is clock.
- stall  input  1  active-high; freezes pc, stack and flags for the cycle.
- op  input  3  sequencing operation, sampled on the clock edge.
- target  input  WIDTH  absolute address (JMP/CALL) or two's-complement offset (BR).
- pc  output  WIDTH  current program counter (registered).
- tc  output  1  registered; 1 exactly when pc == all ones.
- stack_full  output  1  1 when DEPTH entries are held.
- stack_empty  output  1  1 when 0 entries are held.
- stack_err  output  1  sticky; set on CALL-when-full or RET-when-empty.

Behaviour:
- All state updates on rising clock; no combinational path from inputs to outputs.
- Priority per edge: reset low > stall high > op decode.
- Reset (reset==0):
  - pc=RESET_ADDR; stack pointer=0; stack_empty=1; stack_full=0; stack_err=0.
  - tc=(RESET_ADDR==all ones).
  - Stack entry contents are don't-care.
- Stall: pc, stack pointer, stack contents and stack_err are held; op/target ignored.
- op encoding:
  - 000 INC: pc <= pc+1.
  - 001 HOLD: pc unchanged.
  - 010 JMP: pc <= target.
  - 011 BR: pc <= pc + target, target treated as signed.
  - 100 CALL: push pc+1, then pc <= target.
  - 101 RET: pop top entry into pc.
  - 110, 111: treated as INC.
- Arithmetic: all pc sums are modulo 2^WIDTH.
  - INC from all ones wraps to 0.
  - BR wraps in both directions (e.g. WIDTH=8: pc=0x02, target=0xFC gives 0xFE).
  - The pushed return address pc+1 also wraps (pushing from 0xFF stores 0x00).
- tc is registered with pc (it reflects the new pc value); it is not gated by stall or op.
- Stack: LIFO, pointer range 0..DEPTH.
  - stack_full = (ptr==DEPTH); stack_empty = (ptr==0).
  - Flags derive from the registered pointer.
- CALL when stack_full: no push, pc unchanged, stack_err <= 1.
- RET when stack_empty: no pop, pc unchanged, stack_err <= 1.
- stack_err clears only on reset; other ops continue to behave normally after an error.
- Latency: the one-cycle effect of each op is visible on pc the cycle after the sampling edge.
- Back-to-back CALL/RET on consecutive cycles is supported: RET returns the value pushed on the previous edge.
- Reset asserted mid-operation (e.g. during a CALL edge) wins; no push occurs.

Decomposition:
- Shared package pc_seq_pkg holds:
  - op encoding constants (OP_INC, OP_HOLD, OP_JMP, OP_BR, OP_CALL, OP_RET);
  - the function that computes stack-pointer width, clog2(DEPTH+1).
- One sub-module, pc_ret_stack, contains:
  - the register array, pointer and full/empty/error logic;
  - its interface: push, pop, push_data, top_data, full, empty, err.
- The top level holds the pc register, next-pc mux and tc.

Test Plan:
- Reset low 1 cycle with RESET_ADDR=0 -> pc=0x00, tc=0, stack_empty=1, stack_full=0, stack_err=0.
- INC from pc=0xFD for 3 cycles -> pc 0xFE, 0xFF (tc=1), 0x00 (tc=0).
- JMP target=0x40, then BR target=0xF8 -> pc=0x40, then 0x38; BR target=0x10 from 0xF8 -> 0x08.
- DEPTH=4: CALL x4 from pc=0x10 (targets 0x20, 0x30, 0x40, 0x50), then a 5th CALL -> stack_full=1, pc stays 0x50, stack_err=1.
  - Then RET x4 -> pc 0x41, 0x31, 0x21, 0x11, ending with stack_empty=1.
- RET on empty stack from pc=0x05 -> pc stays 0x05, stack_err=1; stays 1 through subsequent INC, clears only on reset low.
- stall=1 with op=CALL target=0x80 at pc=0x12 -> pc, pointer and flags unchanged.
  - Deassert stall -> CALL executes: pc=0x80, top of stack=0x13.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-sequencing counter: op encodings and
// the return-stack pointer sizing helper.
package pc_seq_pkg;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_HOLD = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  // Pointer must represent 0..depth inclusive, hence depth+1 states.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack (LIFO) with registered full/empty flags and a
// sticky misuse error (push when full, pop when empty).
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;

  // Next pointer, entry write and error flag for a push/pop request.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    err_d = err_q;
    if (push) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (PW'(i) == ptr_q) begin
            mem_d[i] = push_data;
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
        ptr_d = ptr_q + PW'(1);
      end
    end else if (pop) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    full_d  = (ptr_d == PW'(DEPTH));
    empty_d = (ptr_d == PW'(0));
  end

  // Top-of-stack read; value is meaningless when empty.
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i + 1) == ptr_q) begin
        top_data = mem_q[i];
      end else begin
        top_data = top_data;
      end
    end
  end

  // Pointer and flag registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q   <= PW'(0);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Entry storage; contents after reset are don't-care so no reset here.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter: increment, hold, jump, relative branch and
// call/return through a hardware return-address stack.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             tc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             tc_q, tc_d;
  logic             push_s, pop_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] ret_addr_s;
  logic             full_s, empty_s, err_s;

  assign ret_addr_s = pc_q + WIDTH'(1);

  // Next-pc mux and stack requests; stall suppresses everything.
  always_comb begin
    pc_d   = pc_q;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_HOLD: pc_d = pc_q;
        OP_JMP:  pc_d = target;
        OP_BR:   pc_d = pc_q + target;
        OP_CALL: begin
          push_s = 1'b1;
          if (full_s) begin
            pc_d = pc_q;
          end else begin
            pc_d = target;
          end
        end
        OP_RET: begin
          pop_s = 1'b1;
          if (empty_s) begin
            pc_d = pc_q;
          end else begin
            pc_d = top_s;
          end
        end
        default: pc_d = ret_addr_s;
      endcase
    end
    tc_d = &pc_d;
  end

  // PC and terminal-count registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_ADDR;
      tc_q <= &RESET_ADDR;
    end else begin
      pc_q <= pc_d;
      tc_q <= tc_d;
    end
  end

  pc_ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(ret_addr_s),
    .top_data (top_s),
    .full     (full_s),
    .empty    (empty_s),
    .err      (err_s)
  );

  assign pc          = pc_q;
  assign tc          = tc_q;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign stack_err   = err_s;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus random ops,
// compared every cycle against a queue-based reference model.
module tb_pc_seq_unit;
  import pc_seq_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam logic [W-1:0] RADDR = 8'h00;

  logic         clock = 1'b0;
  logic         reset;
  logic         stall;
  logic [2:0]   op;
  logic [W-1:0] target;
  logic [W-1:0] pc;
  logic         tc, stack_full, stack_empty, stack_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk [$];
  logic         m_err;

  pc_seq_unit #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(RADDR)) dut (
    .clock(clock), .reset(reset), .stall(stall), .op(op), .target(target),
    .pc(pc), .tc(tc), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: stack is a queue, arithmetic done on integers mod 256.
  task automatic model_apply(input logic r, input logic s, input logic [2:0] o, input logic [W-1:0] t);
    int sum;
    if (!r) begin
      m_pc = RADDR;
      m_stk.delete();
      m_err = 1'b0;
    end else if (!s) begin
      case (o)
        3'd1: ;
        3'd2: m_pc = t;
        3'd3: begin
          sum  = int'(m_pc) + (int'(t) >= 128 ? int'(t) - 256 : int'(t));
          m_pc = W'(((sum % 256) + 256) % 256);
        end
        3'd4: begin
          if (m_stk.size() == D) m_err = 1'b1;
          else begin
            m_stk.push_back(W'((int'(m_pc) + 1) % 256));
            m_pc = t;
          end
        end
        3'd5: begin
          if (m_stk.size() == 0) m_err = 1'b1;
          else m_pc = m_stk.pop_back();
        end
        default: m_pc = W'((int'(m_pc) + 1) % 256);
      endcase
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] o, input logic [W-1:0] t);
    reset = r; stall = s; op = o; target = t;
    @(posedge clock);
    model_apply(r, s, o, t);
    #1;
    check_eq("pc", 32'(pc), 32'(m_pc));
    check_eq("tc", 32'(tc), 32'(m_pc == 8'hFF));
    check_eq("full", 32'(stack_full), 32'(m_stk.size() == D));
    check_eq("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    check_eq("err", 32'(stack_err), 32'(m_err));
  endtask

  initial begin
    m_pc = RADDR; m_err = 1'b0;
    reset = 1'b0; stall = 1'b0; op = OP_HOLD; target = 8'h00;

    step(1'b0, 1'b0, OP_HOLD, 8'h00);
    check_eq("rst_pc", 32'(pc), 32'h00);
    check_eq("rst_empty", 32'(stack_empty), 32'h1);

    step(1'b1, 1'b0, OP_JMP, 8'hFD);
    step(1'b1, 1'b0, OP_INC, 8'h00); check_eq("inc_fe", 32'(pc), 32'hFE);
    step(1'b1, 1'b0, OP_INC, 8'h00); check_eq("inc_ff_tc", 32'(tc), 32'h1);
    step(1'b1, 1'b0, OP_INC, 8'h00); check_eq("inc_wrap", 32'(pc), 32'h00);

    step(1'b1, 1'b0, OP_JMP, 8'h40);
    step(1'b1, 1'b0, OP_BR, 8'hF8);  check_eq("br_back", 32'(pc), 32'h38);
    step(1'b1, 1'b0, OP_JMP, 8'hF8);
    step(1'b1, 1'b0, OP_BR, 8'h10);  check_eq("br_wrap", 32'(pc), 32'h08);

    step(1'b1, 1'b0, OP_JMP, 8'h10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, OP_CALL, W'(8'h20 + 8'h10 * i));
    step(1'b1, 1'b0, OP_CALL, 8'h60);
    check_eq("call_full_pc", 32'(pc), 32'h50);
    check_eq("call_full_err", 32'(stack_err), 32'h1);
    step(1'b1, 1'b0, OP_RET, 8'h00); check_eq("ret1", 32'(pc), 32'h41);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, OP_RET, 8'h00);
    check_eq("ret4", 32'(pc), 32'h11);

    step(1'b0, 1'b0, OP_HOLD, 8'h00);
    step(1'b1, 1'b0, OP_JMP, 8'h05);
    step(1'b1, 1'b0, OP_RET, 8'h00); check_eq("ret_empty_pc", 32'(pc), 32'h05);
    step(1'b1, 1'b0, OP_INC, 8'h00); check_eq("err_sticky", 32'(stack_err), 32'h1);
    step(1'b0, 1'b0, OP_HOLD, 8'h00); check_eq("err_clr", 32'(stack_err), 32'h0);

    step(1'b1, 1'b0, OP_JMP, 8'h12);
    step(1'b1, 1'b1, OP_CALL, 8'h80); check_eq("stall_pc", 32'(pc), 32'h12);
    step(1'b1, 1'b0, OP_CALL, 8'h80); check_eq("call_pc", 32'(pc), 32'h80);
    step(1'b1, 1'b0, OP_RET, 8'h00);  check_eq("ret_top", 32'(pc), 32'h13);

    step(1'b1, 1'b0, OP_CALL, 8'h33);
    step(1'b0, 1'b0, OP_CALL, 8'h44); check_eq("rst_call_empty", 32'(stack_empty), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      logic       r, s;
      logic [2:0] o;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 7) == 0);
      o = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 7));
      step(r, s, o, W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
